lmac_rx_reader: RTL

LMAC_RX_READER -- requirements
Module: lmac_rx_reader

---
 rtl/lmac_rx_reader_if.sv | 30 +++
 rtl/lmac_rx_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lmac_rx_reader_if.sv
// Bus bundle between the MAC RX FIFO, the reader and the downstream consumer.
// The reader uses the slave view; whoever drives the FIFO and consumes words uses master.
interface lmac_rx_reader_if;
   logic        rd_enable;
   logic [63:0] rx_mac_data;
   logic [7:0]  rx_mac_ctrl;
   logic        rx_mac_empty;
   logic        rx_mac_rd;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_sop;
   logic        out_eop;
   logic        out_err;
   logic [10:0] out_len;
   logic        out_ready;
   logic [31:0] pkt_cnt;
   logic [15:0] err_cnt;

   modport slave (
      input  rd_enable, rx_mac_data, rx_mac_ctrl, rx_mac_empty, out_ready,
      output rx_mac_rd, out_data, out_valid, out_sop, out_eop, out_err, out_len,
      output pkt_cnt, err_cnt
   );

   modport master (
      output rd_enable, rx_mac_data, rx_mac_ctrl, rx_mac_empty, out_ready,
      input  rx_mac_rd, out_data, out_valid, out_sop, out_eop, out_err, out_len,
      input  pkt_cnt, err_cnt
   );
endinterface

// File: rtl/lmac_rx_reader.sv
// Pops framed 64-bit words from a FWFT MAC RX FIFO into a one-deep output register,
// checking sop/eop framing, truncating oversize packets and counting good packets and errors.
module lmac_rx_reader #(
   parameter int MAX_WORDS = 1190
) (
   input  logic              clk,
   input  logic              reset,
   lmac_rx_reader_if.slave   bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, PKT = 2'd1, DROP = 2'd2} state_e;

   localparam logic [10:0] MAX_LEN = 11'(MAX_WORDS);

   state_e      state_q, state_d;
   logic [10:0] wcnt_q, wcnt_d;
   logic        valid_q, valid_d;
   logic [63:0] data_q, data_d;
   logic        sop_q, sop_d;
   logic        eop_q, eop_d;
   logic        err_q, err_d;
   logic [10:0] len_q, len_d;
   logic [31:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic        pop_s;
   logic        load_s;
   logic        err_evt_s;
   logic        n_sop_s, n_eop_s, n_err_s;
   logic [10:0] n_len_s;
   logic [10:0] wnext_s;
   logic        in_sop_s, in_eop_s;
   logic        unused_ctrl_s;

   assign in_sop_s      = bus.rx_mac_ctrl[0];
   assign in_eop_s      = bus.rx_mac_ctrl[1];
   assign unused_ctrl_s = ^bus.rx_mac_ctrl[7:2];

   // Reset gates the pop so the FIFO is never drained while the reader is held
   assign pop_s = ~reset & bus.rd_enable & ~bus.rx_mac_empty & (~valid_q | bus.out_ready);

   // Framing FSM, output register load and counter next-state
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      data_d    = data_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      err_d     = err_q;
      len_d     = len_q;
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
      load_s    = 1'b0;
      err_evt_s = 1'b0;
      n_sop_s   = 1'b0;
      n_eop_s   = 1'b0;
      n_err_s   = 1'b0;
      n_len_s   = 11'd0;
      wnext_s   = wcnt_q + 11'd1;

      if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (pop_s) begin
         case (state_q)
            IDLE: begin
               if (in_sop_s) begin
                  load_s  = 1'b1;
                  n_sop_s = 1'b1;
                  if (in_eop_s) begin
                     n_eop_s = 1'b1;
                     n_len_s = 11'd1;
                     wcnt_d  = 11'd0;
                  end else begin
                     wcnt_d  = 11'd1;
                     state_d = PKT;
                  end
               end else begin
                  err_evt_s = 1'b1;
               end
            end
            PKT: begin
               load_s = 1'b1;
               // An unexpected sop closes the current packet as errored
               if (in_sop_s) begin
                  n_eop_s   = 1'b1;
                  n_err_s   = 1'b1;
                  n_len_s   = wnext_s;
                  err_evt_s = 1'b1;
                  wcnt_d    = 11'd0;
                  state_d   = IDLE;
               end else if (in_eop_s) begin
                  n_eop_s = 1'b1;
                  n_len_s = wnext_s;
                  wcnt_d  = 11'd0;
                  state_d = IDLE;
               end else if (wnext_s == MAX_LEN) begin
                  n_eop_s   = 1'b1;
                  n_err_s   = 1'b1;
                  n_len_s   = MAX_LEN;
                  err_evt_s = 1'b1;
                  wcnt_d    = 11'd0;
                  state_d   = DROP;
               end else begin
                  wcnt_d = wnext_s;
               end
            end
            DROP: begin
               if (in_eop_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = DROP;
               end
            end
            default: begin
               wcnt_d  = 11'd0;
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      if (load_s) begin
         valid_d = 1'b1;
         data_d  = bus.rx_mac_data;
         sop_d   = n_sop_s;
         eop_d   = n_eop_s;
         err_d   = n_err_s;
         len_d   = n_len_s;
      end else begin
         data_d  = data_q;
      end

      if (load_s && n_eop_s && !n_err_s) begin
         pkt_cnt_d = pkt_cnt_q + 32'd1;
      end else begin
         pkt_cnt_d = pkt_cnt_q;
      end

      if (err_evt_s && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State, output register and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         wcnt_q    <= 11'd0;
         valid_q   <= 1'b0;
         data_q    <= 64'd0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         err_q     <= 1'b0;
         len_q     <= 11'd0;
         pkt_cnt_q <= 32'd0;
         err_cnt_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         err_q     <= err_d;
         len_q     <= len_d;
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.rx_mac_rd = pop_s;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.out_sop   = sop_q;
   assign bus.out_eop   = eop_q;
   assign bus.out_err   = err_q;
   assign bus.out_len   = len_q;
   assign bus.pkt_cnt   = pkt_cnt_q;
   assign bus.err_cnt   = err_cnt_q;
endmodule
